// File: rtl/gate_sweep_checker.sv
// In-system checker for the two-input gate bank: sweeps a/b through 00..11,
// compares the six gate outputs against the truth table, and reports the result.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       gate_out,
  output logic             a_out,
  output logic             b_out,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [5:0]       fail_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_settleCnt;
  logic [1:0]       r_vecIdx;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_errCount;
  logic [5:0]       r_failMask;

  logic       w_a;
  logic       w_b;
  logic [5:0] w_expected;
  logic [5:0] w_mism;

  // The stimulus bits are the vector index itself, so a/b can never disagree with vec_idx.
  always_comb begin
    w_a        = r_vecIdx[1];
    w_b        = r_vecIdx[0];
    w_expected = {~(w_a & w_b), w_a & w_b, w_a | w_b, ~w_a, ~(w_a | w_b), w_a ^ w_b};
    w_mism     = gate_out ^ w_expected;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_settleCnt <= '0;
      r_vecIdx    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_errCount  <= '0;
      r_failMask  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= SETTLE;
            r_settleCnt <= '0;
            r_vecIdx    <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_errCount  <= '0;
            r_failMask  <= '0;
          end
        end
        SETTLE: begin
          r_settleCnt <= r_settleCnt + 1'b1;
          if (r_settleCnt == CNT_LAST) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_failMask <= r_failMask | w_mism;
          // One count per failing vector, clamped rather than wrapping.
          if ((|w_mism) && (r_errCount != '1)) begin
            r_errCount <= r_errCount + 1'b1;
          end
          if (r_vecIdx == 2'd3) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vecIdx    <= r_vecIdx + 2'd1;
            r_settleCnt <= '0;
            r_state     <= SETTLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out     = w_a;
  assign b_out     = w_b;
  assign vec_idx   = r_vecIdx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_done && (r_errCount == '0);
  assign err_count = r_errCount;
  assign fail_mask = r_failMask;

endmodule
